forward_state_metrics: RTL and testbench

FORWARD_STATE_METRICS -- requirements
Module: forward_state_metrics

---
 rtl/forward_state_metrics.sv | 141 ++++++++++++++
 tb/tb_forward_state_metrics.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/forward_state_metrics.sv
// Forward (alpha) state-metric recursion for a 4-state RSC trellis (1+D+D^2 / 1+D^2), max-product ACS.
// Optional build macro FWD_STATE_METRICS_NORMALIZE_EN: pins state 0 to zero by subtracting it from all metrics.
module forward_state_metrics #(
  parameter int BITS      = 16,
  parameter int FRAME_LEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            frame_start,
  input  logic [BITS-1:0] branch_metric [4],
  output logic            out_valid,
  output logic [BITS-1:0] state_metric  [4],
  output logic            frame_done,
  output logic            err
);

  localparam int ACS_W = BITS + 1;
  localparam int RES_W = BITS + 2;

  localparam logic signed [RES_W-1:0] SAT_MAX  = $signed({3'b000, {(BITS-1){1'b1}}});
  localparam logic signed [RES_W-1:0] SAT_MIN  = $signed({3'b111, {(BITS-1){1'b0}}});
  localparam logic signed [BITS-1:0]  INIT_NEG = $signed({2'b11, {(BITS-2){1'b0}}});
  localparam logic [15:0]             LAST_STEP = 16'(FRAME_LEN);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     step_cnt_q, step_cnt_d;
  logic            out_valid_q, out_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;
  logic [BITS-1:0] alpha_q [4];
  logic [BITS-1:0] alpha_d [4];

  logic                    accept;
  logic                    init_sel;
  logic [15:0]             step_next;
  logic signed [BITS-1:0]  pred [4];
  logic signed [BITS-1:0]  bm   [4];
  logic signed [ACS_W-1:0] acs  [4];
  logic signed [RES_W-1:0] res  [4];

  function automatic logic signed [ACS_W-1:0] add_ext(input logic signed [BITS-1:0] a,
                                                       input logic signed [BITS-1:0] b);
    return $signed({a[BITS-1], a}) + $signed({b[BITS-1], b});
  endfunction

  function automatic logic signed [ACS_W-1:0] max2(input logic signed [ACS_W-1:0] a,
                                                    input logic signed [ACS_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [RES_W-1:0] ext_res(input logic signed [ACS_W-1:0] a);
    return $signed({a[ACS_W-1], a});
  endfunction

  function automatic logic [BITS-1:0] sat(input logic signed [RES_W-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[BITS-1:0];
    if (v < SAT_MIN) return SAT_MIN[BITS-1:0];
    return v[BITS-1:0];
  endfunction

  // Datapath: predecessor select, add-compare-select, optional normalisation, saturation.
  always_comb begin
    init_sel = in_valid & frame_start;
    for (int i = 0; i < 4; i++) begin
      bm[i]   = $signed(branch_metric[i]);
      pred[i] = init_sel ? ((i == 0) ? '0 : INIT_NEG) : $signed(alpha_q[i]);
    end
    acs[0] = max2(add_ext(pred[0], bm[0]), add_ext(pred[1], bm[3]));
    acs[1] = max2(add_ext(pred[2], bm[2]), add_ext(pred[3], bm[1]));
    acs[2] = max2(add_ext(pred[0], bm[3]), add_ext(pred[1], bm[0]));
    acs[3] = max2(add_ext(pred[2], bm[1]), add_ext(pred[3], bm[2]));
    for (int i = 0; i < 4; i++) begin
`ifdef FWD_STATE_METRICS_NORMALIZE_EN
      res[i] = ext_res(acs[i]) - ext_res(acs[0]);
`else
      res[i] = ext_res(acs[i]);
`endif
    end
  end

  // Control FSM and next-state values.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d      = state_q;
    step_cnt_d   = step_cnt_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;
    alpha_d      = alpha_q;
    accept       = in_valid & (frame_start | (state_q == RUN));
    step_next    = step_cnt_q + 16'd1;

    if (in_valid && !frame_start && state_q == IDLE) err_d = 1'b1;

    if (accept) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < 4; i++) alpha_d[i] = sat(res[i]);
      if (frame_start) begin
        state_d    = RUN;
        step_cnt_d = 16'd1;
      end else if (step_next == LAST_STEP) begin
        state_d      = IDLE;
        step_cnt_d   = '0;
        frame_done_d = 1'b1;
      end else begin
        step_cnt_d = step_next;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the metric registers are reset too.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      step_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 4; i++) alpha_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      alpha_q      <= alpha_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign frame_done   = frame_done_q;
  assign err          = err_q;
  assign state_metric = alpha_q;

endmodule

// File: tb/tb_forward_state_metrics.sv
// Directed self-checking bench for forward_state_metrics (BITS=16, FRAME_LEN=4).
// Expected metrics are hand-derived from the trellis map; build-macro dependent values use `ifdef.
module tb_forward_state_metrics;

  localparam int BITS      = 16;
  localparam int FRAME_LEN = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            frame_start;
  logic [BITS-1:0] branch_metric [4];
  logic            out_valid;
  logic [BITS-1:0] state_metric  [4];
  logic            frame_done;
  logic            err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  forward_state_metrics #(.BITS(BITS), .FRAME_LEN(FRAME_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .frame_start  (frame_start),
    .branch_metric(branch_metric),
    .out_valid    (out_valid),
    .state_metric (state_metric),
    .frame_done   (frame_done),
    .err          (err)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_sm(input string tag, input int e0, input int e1, input int e2, input int e3);
    check({tag, "_sm0"}, $signed(state_metric[0]), e0);
    check({tag, "_sm1"}, $signed(state_metric[1]), e1);
    check({tag, "_sm2"}, $signed(state_metric[2]), e2);
    check({tag, "_sm3"}, $signed(state_metric[3]), e3);
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cycle(input logic r, input logic v, input logic fs,
                       input int b0, input int b1, input int b2, input int b3);
    reset            = r;
    in_valid         = v;
    frame_start      = fs;
    branch_metric[0] = 16'(b0);
    branch_metric[1] = 16'(b1);
    branch_metric[2] = 16'(b2);
    branch_metric[3] = 16'(b3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic gap_v [6];
    logic rs_fs [6];
    logic r4_fs [7];
    int   n_valid;

    gap_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rs_fs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    r4_fs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset held two cycles.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    check_sm("rst", 0, 0, 0, 0);

    // Init step, then a second step with distinct metrics, then a hold cycle.
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 10, 0, 0, 0);
    check("init_out_valid", out_valid, 1);
`ifdef FWD_STATE_METRICS_NORMALIZE_EN
    check_sm("init", 0, -16394, -10, -16394);
    cycle(0, 1, 0, 1, 2, 3, 4);
    check_sm("step2", 0, -8, 3, -9);
    cycle(0, 0, 0, 99, 99, 99, 99);
    check("hold_out_valid", out_valid, 0);
    check_sm("hold", 0, -8, 3, -9);
`else
    check_sm("init", 10, -16384, 0, -16384);
    cycle(0, 1, 0, 1, 2, 3, 4);
    check_sm("step2", 11, 3, 14, 2);
    cycle(0, 0, 0, 99, 99, 99, 99);
    check("hold_out_valid", out_valid, 0);
    check_sm("hold", 11, 3, 14, 2);

    // Positive saturation over two steps, then negative saturation on a restart.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 32767, 32767, 32767, 32767);
    check("sat1_sm0", $signed(state_metric[0]), 32767);
    check("sat1_sm1", $signed(state_metric[1]), 16383);
    cycle(0, 1, 0, 32767, 32767, 32767, 32767);
    check("sat2_out_valid", out_valid, 1);
    check_sm("sat2", 32767, 32767, 32767, 32767);
    cycle(0, 1, 1, -32768, -32768, -32768, -32768);
    check_sm("satneg", -32768, -32768, -32768, -32768);
`endif

    // Gapped frame: in_valid 1,0,1,1,0,1 gives four steps, frame_done only on the fourth.
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_valid = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, gap_v[i], (i == 0), 0, 0, 0, 0);
      if (gap_v[i]) n_valid++;
      check($sformatf("gap%0d_out_valid", i), out_valid, gap_v[i]);
      check($sformatf("gap%0d_frame_done", i), frame_done, (gap_v[i] && n_valid == FRAME_LEN));
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("gap_after_out_valid", out_valid, 0);
    check("gap_after_err", err, 0);

    // Back in IDLE: in_valid without frame_start is rejected and flags err.
    cycle(0, 1, 0, 5, 5, 5, 5);
    check("idle_err_out_valid", out_valid, 0);
    check("idle_err_err", err, 1);
    for (int i = 0; i < FRAME_LEN; i++) begin
      cycle(0, 1, (i == 0), 0, 0, 0, 0);
      check($sformatf("legal%0d_out_valid", i), out_valid, 1);
      check($sformatf("legal%0d_frame_done", i), frame_done, (i == FRAME_LEN - 1));
    end
    check("legal_err_sticky", err, 1);

    // Restart on step 3: re-init and frame_done four steps after the restart.
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, rs_fs[i], (i == 2) ? 10 : 7, 0, 0, 0);
      check($sformatf("rs%0d_out_valid", i), out_valid, 1);
      check($sformatf("rs%0d_frame_done", i), frame_done, (i == 5));
`ifdef FWD_STATE_METRICS_NORMALIZE_EN
      if (i == 2) check_sm("rs_reinit", 0, -16394, -10, -16394);
`else
      if (i == 2) check_sm("rs_reinit", 10, -16384, 0, -16384);
`endif
    end

    // Restart landing on step FRAME_LEN: no frame_done there, stays in RUN.
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, r4_fs[i], 0, 0, 0, 0);
      check($sformatf("r4_%0d_out_valid", i), out_valid, 1);
      check($sformatf("r4_%0d_frame_done", i), frame_done, (i == 6));
    end

    // Reset on step 2 of a frame: no out_valid, frame abandoned, back in IDLE.
    cycle(0, 1, 1, 3, 0, 0, 0);
    check("mid_first_out_valid", out_valid, 1);
    cycle(1, 1, 0, 3, 0, 0, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_err", err, 0);
    check_sm("mid_rst", 0, 0, 0, 0);
    cycle(0, 1, 0, 3, 0, 0, 0);
    check("mid_idle_out_valid", out_valid, 0);
    check("mid_idle_err", err, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
